// File: rtl/countdown_pkg.sv
// Shared types, segment codes and BCD helpers for the countdown display controller.
package countdown_pkg;

    localparam int DIGIT_W = 4;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        PAUSE = 2'd2,
        DONE  = 2'd3
    } state_t;

    // Active-low {a,b,c,d,e,f,g}
    localparam logic [6:0] SEG_0   = 7'b0000001;
    localparam logic [6:0] SEG_1   = 7'b1001111;
    localparam logic [6:0] SEG_2   = 7'b0010010;
    localparam logic [6:0] SEG_3   = 7'b0000110;
    localparam logic [6:0] SEG_4   = 7'b1001100;
    localparam logic [6:0] SEG_5   = 7'b0100100;
    localparam logic [6:0] SEG_6   = 7'b0100000;
    localparam logic [6:0] SEG_7   = 7'b0001111;
    localparam logic [6:0] SEG_8   = 7'b0000000;
    localparam logic [6:0] SEG_9   = 7'b0000100;
    localparam logic [6:0] SEG_OFF = 7'b1111111;

    function automatic logic [6:0] seg_encode(input logic [DIGIT_W-1:0] digit);
        case (digit)
            4'd0:    seg_encode = SEG_0;
            4'd1:    seg_encode = SEG_1;
            4'd2:    seg_encode = SEG_2;
            4'd3:    seg_encode = SEG_3;
            4'd4:    seg_encode = SEG_4;
            4'd5:    seg_encode = SEG_5;
            4'd6:    seg_encode = SEG_6;
            4'd7:    seg_encode = SEG_7;
            4'd8:    seg_encode = SEG_8;
            4'd9:    seg_encode = SEG_9;
            default: seg_encode = SEG_OFF;
        endcase
    endfunction

    function automatic logic [15:0] clamp_bcd(input logic [15:0] value);
        logic [15:0] result;
        result = '0;
        for (int i = 0; i < 4; i++) begin
            if (value[i*DIGIT_W +: DIGIT_W] > 4'd9)
                result[i*DIGIT_W +: DIGIT_W] = 4'd9;
            else
                result[i*DIGIT_W +: DIGIT_W] = value[i*DIGIT_W +: DIGIT_W];
        end
        return result;
    endfunction

    // Ripple borrow: a zero digit wraps to 9 and passes the borrow upward
    function automatic logic [15:0] bcd_decrement(input logic [15:0] value);
        logic [15:0] result;
        logic        borrow;
        result = value;
        borrow = 1'b1;
        for (int i = 0; i < 4; i++) begin
            if (borrow) begin
                if (value[i*DIGIT_W +: DIGIT_W] == 4'd0) begin
                    result[i*DIGIT_W +: DIGIT_W] = 4'd9;
                end else begin
                    result[i*DIGIT_W +: DIGIT_W] = value[i*DIGIT_W +: DIGIT_W] - 4'd1;
                    borrow = 1'b0;
                end
            end
        end
        return result;
    endfunction

endpackage

// File: rtl/countdown_ctrl_if.sv
// Button inputs and display outputs of the countdown controller.
interface countdown_ctrl_if;
    logic        start_btn;
    logic        stop_btn;
    logic        load_btn;
    logic [15:0] load_val;
    logic [6:0]  seg;
    logic [3:0]  an;
    logic        running;
    logic        done;

    modport master (
        output start_btn, stop_btn, load_btn, load_val,
        input  seg, an, running, done
    );

    modport slave (
        input  start_btn, stop_btn, load_btn, load_val,
        output seg, an, running, done
    );
endinterface

// File: rtl/countdown_ctrl_seg7_decode.sv
// BCD digit to active-low seven-segment pattern; non-decimal codes blank the digit.
module seg7_decode
    import countdown_pkg::*;
(
    input  logic [DIGIT_W-1:0] digit,
    output logic [6:0]         seg
);
    always_comb begin
        seg = seg_encode(digit);
    end
endmodule

// File: rtl/countdown_ctrl.sv
// Start/pause/load/done countdown sequencer with a multiplexed 4-digit display scan.
module countdown_ctrl
    import countdown_pkg::*;
#(
    parameter int unsigned TICK_DIV  = 100_000_000,
    parameter int unsigned SCAN_DIV  = 100_000,
    parameter logic [15:0] START_VAL = 16'h0100
) (
    input  logic           clk,
    input  logic           rst_n,
    countdown_ctrl_if.slave bus
);
    localparam int TICK_W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam int SCAN_W = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
    localparam logic [TICK_W-1:0] TICK_LAST = TICK_W'(TICK_DIV - 1);
    localparam logic [SCAN_W-1:0] SCAN_LAST = SCAN_W'(SCAN_DIV - 1);

    state_t              state, state_next;
    logic [15:0]         count, count_next;
    logic [TICK_W-1:0]   tick_cnt, tick_next;
    logic [SCAN_W-1:0]   scan_cnt, scan_next;
    logic [1:0]          digit_sel, sel_next;
    logic                start_prev, stop_prev, load_prev;
    logic                start_ev, stop_ev, load_ev;
    logic                tick_hit;
    logic [15:0]         dec_val;
    logic [DIGIT_W-1:0]  shown_digit;
    logic [6:0]          seg_next;
    logic [6:0]          seg_q;
    logic [3:0]          an_q;

    assign start_ev = bus.start_btn & ~start_prev;
    assign stop_ev  = bus.stop_btn  & ~stop_prev;
    assign load_ev  = bus.load_btn  & ~load_prev;
    assign tick_hit = (tick_cnt == TICK_LAST);
    assign dec_val  = bcd_decrement(count);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            count      <= START_VAL;
            tick_cnt   <= '0;
            start_prev <= 1'b0;
            stop_prev  <= 1'b0;
            load_prev  <= 1'b0;
        end else begin
            state      <= state_next;
            count      <= count_next;
            tick_cnt   <= tick_next;
            start_prev <= bus.start_btn;
            stop_prev  <= bus.stop_btn;
            load_prev  <= bus.load_btn;
        end
    end

    // Only the highest-priority event (load, then stop, then start) is acted on;
    // any event in RUN swallows a coinciding decrement.
    always_comb begin
        state_next = state;
        count_next = count;
        tick_next  = tick_cnt;
        case (state)
            IDLE: begin
                if (load_ev) begin
                    count_next = clamp_bcd(bus.load_val);
                end else if (!stop_ev && start_ev) begin
                    state_next = (count != '0) ? RUN : DONE;
                    tick_next  = '0;
                end
            end
            RUN: begin
                if (load_ev) begin
                    count_next = clamp_bcd(bus.load_val);
                    state_next = IDLE;
                end else if (stop_ev) begin
                    state_next = PAUSE;
                end else begin
                    tick_next = tick_hit ? '0 : tick_cnt + TICK_W'(1);
                    if (tick_hit && !start_ev) begin
                        count_next = dec_val;
                        if (dec_val == '0)
                            state_next = DONE;
                    end
                end
            end
            PAUSE: begin
                if (load_ev) begin
                    count_next = clamp_bcd(bus.load_val);
                    state_next = IDLE;
                end else if (!stop_ev && start_ev) begin
                    state_next = RUN;
                    tick_next  = '0;
                end
            end
            DONE: begin
                if (load_ev) begin
                    count_next = clamp_bcd(bus.load_val);
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    always_comb begin
        scan_next = scan_cnt + SCAN_W'(1);
        sel_next  = digit_sel;
        if (scan_cnt == SCAN_LAST) begin
            scan_next = '0;
            sel_next  = digit_sel + 2'd1;
        end
    end

    // Decode from next-cycle values so seg always matches the anode lit beside it
    assign shown_digit = count_next[sel_next*DIGIT_W +: DIGIT_W];

    seg7_decode u_decode (
        .digit (shown_digit),
        .seg   (seg_next)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            scan_cnt  <= '0;
            digit_sel <= 2'd0;
            an_q      <= 4'b1110;
            seg_q     <= seg_encode(START_VAL[DIGIT_W-1:0]);
        end else begin
            scan_cnt  <= scan_next;
            digit_sel <= sel_next;
            an_q      <= ~(4'b0001 << sel_next);
            seg_q     <= seg_next;
        end
    end

    assign bus.seg     = seg_q;
    assign bus.an      = an_q;
    assign bus.running = (state == RUN);
    assign bus.done    = (state == DONE);

endmodule
